// File: rtl/counter_b4_sched.sv
// Two-requester job scheduler driving a 4-bit counter: arbitrates, runs a
// counting or load job for a latched cycle count, then pulses the owner's done.
module counter_b4_sched #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic       b4_clk,
    input  logic       b4_reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] mode0,
    input  logic [1:0] mode1,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic       b4_rco,
    output logic       b4_enable,
    output logic [1:0] b4_mode,
    output logic [3:0] b4_D,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       ovf,
    output logic       busy
);

    localparam int unsigned MODE_W = 2;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned CNT_W  = 4;
    localparam logic [MODE_W-1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_owner;
    logic                r_last;
    logic [MODE_W-1:0]   r_mode;
    logic [DATA_W-1:0]   r_d;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;

    logic                w_any;
    logic                w_win;
    logic [MODE_W-1:0]   w_mode;
    logic [DATA_W-1:0]   w_d;
    logic [CNT_W-1:0]    w_len;
    logic [CNT_W-1:0]    w_cnt;

    // Winner selection; r_last==1 means requester 1 was granted last.
    always_comb begin
        w_any = req0 | req1;
        w_win = 1'b0;
        if (req0 && req1) begin
            w_win = PRIO_FIXED ? 1'b0 : ~r_last;
        end else begin
            w_win = ~req0;
        end
        w_mode = w_win ? mode1 : mode0;
        w_d    = w_win ? d1    : d0;
        w_len  = w_win ? len1  : len0;
        w_cnt  = (w_mode == MODE_LOAD) ? CNT_W'(1) : w_len;
    end

    always_ff @(posedge b4_clk or negedge b4_reset_n) begin
        if (!b4_reset_n) begin
            r_state   <= ST_IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_mode    <= '0;
            r_d       <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            b4_enable <= 1'b0;
            b4_mode   <= '0;
            b4_D      <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    ovf   <= 1'b0;
                    if (w_any) begin
                        r_owner <= w_win;
                        r_last  <= w_win;
                        r_mode  <= w_mode;
                        r_d     <= w_d;
                        r_cnt   <= w_cnt;
                        r_ovf   <= 1'b0;
                        busy    <= 1'b1;
                        if (w_cnt == '0) begin
                            // Zero-length job: straight to the done pulse, never enabled.
                            r_state   <= ST_DONE;
                            b4_enable <= 1'b0;
                            b4_mode   <= '0;
                            b4_D      <= '0;
                            gnt0      <= 1'b0;
                            gnt1      <= 1'b0;
                            done0     <= ~w_win;
                            done1     <= w_win;
                        end else begin
                            r_state   <= ST_RUN;
                            b4_enable <= 1'b1;
                            b4_mode   <= w_mode;
                            b4_D      <= w_d;
                            gnt0      <= ~w_win;
                            gnt1      <= w_win;
                        end
                    end else begin
                        b4_enable <= 1'b0;
                        b4_mode   <= '0;
                        b4_D      <= '0;
                        gnt0      <= 1'b0;
                        gnt1      <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    r_ovf <= r_ovf | b4_rco;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state   <= ST_DONE;
                        b4_enable <= 1'b0;
                        b4_mode   <= '0;
                        b4_D      <= '0;
                        gnt0      <= 1'b0;
                        gnt1      <= 1'b0;
                        done0     <= ~r_owner;
                        done1     <= r_owner;
                        ovf       <= r_ovf | b4_rco;
                    end else begin
                        b4_enable <= 1'b1;
                        b4_mode   <= r_mode;
                        b4_D      <= r_d;
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    b4_enable <= 1'b0;
                    b4_mode   <= '0;
                    b4_D      <= '0;
                    gnt0      <= 1'b0;
                    gnt1      <= 1'b0;
                    done0     <= 1'b0;
                    done1     <= 1'b0;
                    ovf       <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
